// File: rtl/image_sobel_edge_detector.sv
// Sobel edge stage on the Y stream: two line buffers form a 3x3 window, |Gx|+|Gy| is
// pipelined and thresholded; sync signals are delayed to line up with the result.
module image_sobel_edge_detector #(
  parameter int unsigned IMG_HDISP = 640,
  parameter logic [10:0] THRESHOLD = 11'd96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_mag,
  output logic       post_img_bit
);

  localparam int unsigned COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned ROW_W = 12;
  localparam int unsigned DLY   = 4;

  logic             pix_c;
  logic             href_fall_c;
  logic             href_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       lb0_q [IMG_HDISP];
  logic [7:0]       lb1_q [IMG_HDISP];
  logic [7:0]       p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q;
  logic             v0_q, v1_q, v2_q;
  logic signed [10:0] gx_q, gy_q, gx_d, gy_d;
  logic [9:0]       ax_q, ay_q;
  logic [10:0]      mag_c;
  logic [DLY-1:0]   vs_q, hr_q, ck_q;

  assign pix_c       = per_frame_clken & per_frame_href;
  assign href_fall_c = href_q & ~per_frame_href;

  // Column counter saturates on over-long lines; row counter restarts every frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (href_fall_c) begin
      col_d = '0;
    end else if (pix_c && (col_q != COL_W'(IMG_HDISP - 1))) begin
      col_d = col_q + COL_W'(1);
    end
    if (!per_frame_vsync) begin
      row_d = '0;
    end else if (href_fall_c && (row_q != '1)) begin
      row_d = row_q + ROW_W'(1);
    end
  end

  always_comb begin
    gx_d = $signed(11'(p13_q) + (11'(p23_q) << 1) + 11'(p33_q)
                 - 11'(p11_q) - (11'(p21_q) << 1) - 11'(p31_q));
    gy_d = $signed(11'(p11_q) + (11'(p12_q) << 1) + 11'(p13_q)
                 - 11'(p31_q) - (11'(p32_q) << 1) - 11'(p33_q));
  end

  assign mag_c = 11'(ax_q) + 11'(ay_q);

  // Line buffers shift one entry per accepted pixel; tails give the same column one and two lines up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(IMG_HDISP); i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (pix_c) begin
      lb0_q[0] <= per_img_Y;
      lb1_q[0] <= lb0_q[IMG_HDISP-1];
      for (int i = 1; i < int'(IMG_HDISP); i++) begin
        lb0_q[i] <= lb0_q[i-1];
        lb1_q[i] <= lb1_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      href_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      {p11_q, p12_q, p13_q, p21_q, p22_q, p23_q, p31_q, p32_q, p33_q} <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      post_img_mag <= '0;
      post_img_bit <= 1'b0;
      vs_q   <= '0;
      hr_q   <= '0;
      ck_q   <= '0;
    end else begin
      href_q <= per_frame_href;
      col_q  <= col_d;
      row_q  <= row_d;
      if (pix_c) begin
        {p11_q, p12_q, p13_q} <= {p12_q, p13_q, lb1_q[IMG_HDISP-1]};
        {p21_q, p22_q, p23_q} <= {p22_q, p23_q, lb0_q[IMG_HDISP-1]};
        {p31_q, p32_q, p33_q} <= {p32_q, p33_q, per_img_Y};
        v0_q <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      end
      gx_q <= gx_d;
      gy_q <= gy_d;
      v1_q <= v0_q;
      ax_q <= gx_q[10] ? 10'(-gx_q) : 10'(gx_q);
      ay_q <= gy_q[10] ? 10'(-gy_q) : 10'(gy_q);
      v2_q <= v1_q;
      post_img_bit <= v2_q && (mag_c > THRESHOLD);
      post_img_mag <= !v2_q ? 8'd0 : ((mag_c > 11'd255) ? 8'hFF : mag_c[7:0]);
      vs_q <= {vs_q[DLY-2:0], per_frame_vsync};
      hr_q <= {hr_q[DLY-2:0], per_frame_href};
      ck_q <= {ck_q[DLY-2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vs_q[DLY-1];
  assign post_frame_href  = hr_q[DLY-1];
  assign post_frame_clken = ck_q[DLY-1];

endmodule
